// File: rtl/truth_table_sweeper_if.sv
// Control/status and DUT-facing bus of the truth-table sweeper.
// slave = sweeper side, master = host side that also owns the DUT under check.
`timescale 1ns/1ps
interface truth_table_sweeper_if #(
    parameter int N_IN  = 2,
    parameter int N_OUT = 2
);
    logic              start;
    logic [N_IN-1:0]   dut_in;
    logic [N_OUT-1:0]  dut_out;
    logic              busy;
    logic              done;
    logic              pass;
    logic              mismatch;
    logic [N_IN:0]     err_count;
    logic [N_IN-1:0]   first_err_idx;

    modport master (
        output start, dut_out,
        input  dut_in, busy, done, pass, mismatch, err_count, first_err_idx
    );

    modport slave (
        input  start, dut_out,
        output dut_in, busy, done, pass, mismatch, err_count, first_err_idx
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweep of a small combinational block: drive each index,
// wait SETTLE cycles, compare the response with a packed expected table.
`timescale 1ns/1ps
module truth_table_sweeper #(
    parameter int N_IN   = 2,
    parameter int N_OUT  = 2,
    parameter int SETTLE = 1,
    parameter logic [(2**N_IN)*N_OUT-1:0] EXPECTED = 8'h3F
) (
    input  logic                 clk,
    input  logic                 reset,
    truth_table_sweeper_if.slave sw
);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0]   SETTLE_LOAD = SW'(SETTLE - 1);
    localparam logic [N_IN-1:0] LAST_IDX    = '1;
    localparam logic [N_IN-1:0] IDX_ONE     = N_IN'(1);
    localparam logic [N_IN:0]   ERR_ONE     = (N_IN + 1)'(1);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

    state_t            state;
    logic [N_IN-1:0]   idx;
    logic [SW-1:0]     settle_cnt;
    logic [N_OUT-1:0]  exp_vec;
    logic              miss;
    logic [N_IN:0]     err_next;

    // Case inequality so X/Z on the response is scored as a failure.
    always_comb begin
        exp_vec  = EXPECTED[int'(idx)*N_OUT +: N_OUT];
        miss     = (sw.dut_out !== exp_vec);
        err_next = miss ? sw.err_count + ERR_ONE : sw.err_count;
    end

    // The pulse has to land in the CHECK cycle itself, so it stays combinational.
    assign sw.mismatch = (state == S_CHECK) && miss;
    assign sw.dut_in   = idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            idx              <= '0;
            settle_cnt       <= '0;
            sw.busy          <= 1'b0;
            sw.done          <= 1'b0;
            sw.pass          <= 1'b0;
            sw.err_count     <= '0;
            sw.first_err_idx <= '0;
        end else begin
            sw.done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (sw.start) begin
                        state            <= S_SETTLE;
                        idx              <= '0;
                        settle_cnt       <= SETTLE_LOAD;
                        sw.busy          <= 1'b1;
                        sw.pass          <= 1'b0;
                        sw.err_count     <= '0;
                        sw.first_err_idx <= '0;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == '0) state <= S_CHECK;
                    else                  settle_cnt <= settle_cnt - SW'(1);
                end
                S_CHECK: begin
                    sw.err_count <= err_next;
                    if (miss && sw.err_count == '0) sw.first_err_idx <= idx;
                    if (idx == LAST_IDX) begin
                        state   <= S_DONE;
                        sw.done <= 1'b1;
                        sw.busy <= 1'b0;
                        sw.pass <= (err_next == '0);
                    end else begin
                        state      <= S_SETTLE;
                        idx        <= idx + IDX_ONE;
                        settle_cnt <= SETTLE_LOAD;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: five sweeper instances against nand and delayed-inverter DUTs.
`timescale 1ns/1ps
module tb_truth_table_sweeper;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   dones;

    always #5 clk = ~clk;

    truth_table_sweeper_if #(.N_IN(2), .N_OUT(2)) ifa ();
    truth_table_sweeper_if #(.N_IN(2), .N_OUT(2)) ifb ();
    truth_table_sweeper_if #(.N_IN(2), .N_OUT(2)) ifc ();
    truth_table_sweeper_if #(.N_IN(3), .N_OUT(2)) ifd ();
    truth_table_sweeper_if #(.N_IN(3), .N_OUT(2)) ife ();

    // fxy: both outputs are nand(x, y), x = dut_in[1]
    assign ifa.dut_out = {2{~(ifa.dut_in[1] & ifa.dut_in[0])}};
    assign ifb.dut_out = {2{~(ifb.dut_in[1] & ifb.dut_in[0])}};
    assign ifc.dut_out = {2{~(ifc.dut_in[1] & ifc.dut_in[0])}};

    // Inverter chain with two register stages of delay
    logic [1:0] d_r1, d_r2, e_r1, e_r2;
    always @(posedge clk) begin
        if (reset) begin
            d_r1 <= 2'b11; d_r2 <= 2'b11; e_r1 <= 2'b11; e_r2 <= 2'b11;
        end else begin
            d_r1 <= ~ifd.dut_in[1:0]; d_r2 <= d_r1;
            e_r1 <= ~ife.dut_in[1:0]; e_r2 <= e_r1;
        end
    end
    assign ifd.dut_out = d_r2;
    assign ife.dut_out = e_r2;

    truth_table_sweeper #(.N_IN(2), .N_OUT(2), .SETTLE(1), .EXPECTED(8'h3F))
        u_a (.clk(clk), .reset(reset), .sw(ifa));
    truth_table_sweeper #(.N_IN(2), .N_OUT(2), .SETTLE(1), .EXPECTED(8'h3E))
        u_b (.clk(clk), .reset(reset), .sw(ifb));
    truth_table_sweeper #(.N_IN(2), .N_OUT(2), .SETTLE(1), .EXPECTED(8'h00))
        u_c (.clk(clk), .reset(reset), .sw(ifc));
    truth_table_sweeper #(.N_IN(3), .N_OUT(2), .SETTLE(3), .EXPECTED(16'h1B1B))
        u_d (.clk(clk), .reset(reset), .sw(ifd));
    truth_table_sweeper #(.N_IN(3), .N_OUT(2), .SETTLE(1), .EXPECTED(16'h1B1B))
        u_e (.clk(clk), .reset(reset), .sw(ife));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a_reset(input string tag);
        chk({tag, " dut_in"}, 32'(ifa.dut_in), 0);
        chk({tag, " busy"}, 32'(ifa.busy), 0);
        chk({tag, " done"}, 32'(ifa.done), 0);
        chk({tag, " pass"}, 32'(ifa.pass), 0);
        chk({tag, " mismatch"}, 32'(ifa.mismatch), 0);
        chk({tag, " err_count"}, 32'(ifa.err_count), 0);
        chk({tag, " first_err_idx"}, 32'(ifa.first_err_idx), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        ifa.start = 1'b0; ifb.start = 1'b0; ifc.start = 1'b0;
        ifd.start = 1'b0; ife.start = 1'b0;
        repeat (3) @(negedge clk);
        chk_a_reset("reset");
        chk("reset d busy", 32'(ifd.busy), 0);
        reset = 1'b0;
        @(negedge clk);

        // Tests 1-3: clean sweep, one mismatch, three mismatches
        ifa.start = 1'b1; ifb.start = 1'b1; ifc.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0; ifb.start = 1'b0; ifc.start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (k <= 8) begin
                chk($sformatf("t1 dut_in k=%0d", k), 32'(ifa.dut_in), 32'((k - 1) >> 1));
                chk($sformatf("t1 busy k=%0d", k), 32'(ifa.busy), 1);
                chk($sformatf("t1 done k=%0d", k), 32'(ifa.done), 0);
            end
            chk($sformatf("t1 mismatch k=%0d", k), 32'(ifa.mismatch), 0);
            chk($sformatf("t2 mismatch k=%0d", k), 32'(ifb.mismatch), 32'(k == 2));
            chk($sformatf("t3 mismatch k=%0d", k), 32'(ifc.mismatch),
                32'(k == 2 || k == 4 || k == 6));
            if (k == 9) begin
                chk("t1 done", 32'(ifa.done), 1);
                chk("t1 busy end", 32'(ifa.busy), 0);
                chk("t1 pass", 32'(ifa.pass), 1);
                chk("t1 err_count", 32'(ifa.err_count), 0);
                chk("t1 dut_in hold", 32'(ifa.dut_in), 3);
                chk("t2 done", 32'(ifb.done), 1);
                chk("t2 err_count", 32'(ifb.err_count), 1);
                chk("t2 first_err_idx", 32'(ifb.first_err_idx), 0);
                chk("t2 pass", 32'(ifb.pass), 0);
                chk("t3 err_count", 32'(ifc.err_count), 3);
                chk("t3 first_err_idx", 32'(ifc.first_err_idx), 0);
                chk("t3 pass", 32'(ifc.pass), 0);
            end
            if (k == 10) begin
                chk("t1 done drop", 32'(ifa.done), 0);
                chk("t1 pass held", 32'(ifa.pass), 1);
            end
            @(negedge clk);
        end

        // Test 4: sample timing against a two-cycle delayed DUT
        ifd.start = 1'b1; ife.start = 1'b1;
        @(negedge clk);
        ifd.start = 1'b0; ife.start = 1'b0;
        for (int k = 1; k <= 34; k++) begin
            if (k == 16) chk("t4 e done early", 32'(ife.done), 0);
            if (k == 17) begin
                chk("t4 e done", 32'(ife.done), 1);
                chk("t4 e pass", 32'(ife.pass), 0);
                chk("t4 e err_count", 32'(ife.err_count), 7);
                chk("t4 e first_err_idx", 32'(ife.first_err_idx), 1);
            end
            if (k == 32) chk("t4 d done early", 32'(ifd.done), 0);
            if (k == 33) begin
                chk("t4 d done", 32'(ifd.done), 1);
                chk("t4 d pass", 32'(ifd.pass), 1);
                chk("t4 d err_count", 32'(ifd.err_count), 0);
            end
            @(negedge clk);
        end

        // Test 5: reset during CHECK of idx2, then a clean sweep
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        repeat (5) @(negedge clk);
        chk("t5 in check idx2", 32'(ifa.dut_in), 2);
        chk("t5 busy before reset", 32'(ifa.busy), 1);
        reset = 1'b1;
        @(negedge clk);
        chk_a_reset("t5 after reset");
        reset = 1'b0;
        @(negedge clk);
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            if (k <= 8) chk($sformatf("t5 dut_in k=%0d", k), 32'(ifa.dut_in), 32'((k - 1) >> 1));
            chk($sformatf("t5 done k=%0d", k), 32'(ifa.done), 32'(k == 9));
            if (k == 9) begin
                chk("t5 pass", 32'(ifa.pass), 1);
                chk("t5 err_count", 32'(ifa.err_count), 0);
            end
            @(negedge clk);
        end

        // Test 6: start held high across the sweep
        dones = 0;
        ifa.start = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 19; k++) begin
            if (k <= 10 && ifa.done) dones++;
            if (k == 10) begin
                chk("t6 single done", 32'(dones), 1);
                chk("t6 idle busy", 32'(ifa.busy), 0);
                chk("t6 idle done", 32'(ifa.done), 0);
            end
            if (k == 11) begin
                chk("t6 restart busy", 32'(ifa.busy), 1);
                chk("t6 restart dut_in", 32'(ifa.dut_in), 0);
                chk("t6 restart pass clr", 32'(ifa.pass), 0);
                ifa.start = 1'b0;
            end
            if (k == 18) chk("t6 second done early", 32'(ifa.done), 0);
            if (k == 19) begin
                chk("t6 second done", 32'(ifa.done), 1);
                chk("t6 second pass", 32'(ifa.pass), 1);
            end
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
